iir_inverse: RTL

Streaming inverse (deconvolution) filter for the first-order recursive section y[n] = x[n-1] + (y[n-1]>>>1) + (y[n-1]>>>2). Each accepted sample y[k] produces x_hat[k] = y[k] − (y[k-1]>>>1) − (y[k-1]>>>2), with y[-1] = 0, which matches the recursive section's reset state. The block sits on the receive/equalizer side of a data path that applies that recursive section, and recovers its excitation. Input and output use valid/ready handshakes through a 2-stage pipeline with backpressure.

---
 rtl/iir_inverse_if.sv | 22 ++
 rtl/iir_inverse.sv | 108 ++++++++++
 2 files changed

// File: rtl/iir_inverse_if.sv
// Sample stream bundle for iir_inverse: input y[k] and output x_hat[k] valid/ready channels.
// slave is the filter's view; master is the source/sink side.
interface iir_inverse_if #(
  parameter int unsigned W = 14
);
  logic [W:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [W:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/iir_inverse.sv
// Inverse of y[n] = x[n-1] + (y[n-1]>>>1) + (y[n-1]>>>2): x_hat = y - (yp>>>1) - (yp>>>2),
// 2-stage valid/ready pipeline. Define IIR_INVERSE_SAT_EN to saturate instead of wrap on overflow.
module iir_inverse #(
  parameter int unsigned W = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  iir_inverse_if.slave  bus,
  output logic          ovf
);

  localparam int unsigned EW = W + 3;

  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic [W:0]    yp_q, yp_d;
  logic [W:0]    s1_y_q, s1_y_d;
  logic [W:0]    s1_yp_q, s1_yp_d;
  logic [W:0]    out_q, out_d;
  logic          ovf_q, ovf_d;

  logic          en1, en2, in_xfer;
  logic signed [EW-1:0] y_ext, yp_ext, diff;
  logic          diff_ovf;
  logic [W:0]    result;

  // Stall chain: a stage may load when it is empty or the stage after it frees up
  assign en2       = !v2_q || bus.out_ready;
  assign en1       = !v1_q || en2;
  assign bus.in_ready = en1 && !clear;
  assign in_xfer   = bus.in_valid && bus.in_ready;

  assign bus.out_data  = out_q;
  assign bus.out_valid = v2_q;
  assign ovf           = ovf_q;

  // Difference computed from the stage-1 registers in W+3 bits so it cannot wrap internally
  always_comb begin
    y_ext    = {{2{s1_y_q[W]}}, s1_y_q};
    yp_ext   = {{2{s1_yp_q[W]}}, s1_yp_q};
    diff     = y_ext - (yp_ext >>> 1) - (yp_ext >>> 2);
    diff_ovf = !((&diff[EW-1:W]) || !(|diff[EW-1:W]));
`ifdef IIR_INVERSE_SAT_EN
    if (diff_ovf) begin
      result = diff[EW-1] ? {1'b1, {W{1'b0}}} : {1'b0, {W{1'b1}}};
    end else begin
      result = diff[W:0];
    end
`else
    result = diff[W:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      yp_q    <= '0;
      s1_y_q  <= '0;
      s1_yp_q <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      yp_q    <= yp_d;
      s1_y_q  <= s1_y_d;
      s1_yp_q <= s1_yp_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: clear flushes occupancy and history but keeps the sticky overflow flag
  always_comb begin
    v1_d    = v1_q;
    v2_d    = v2_q;
    yp_d    = yp_q;
    s1_y_d  = s1_y_q;
    s1_yp_d = s1_yp_q;
    out_d   = out_q;
    ovf_d   = ovf_q;

    if (clear) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      yp_d = '0;
    end else begin
      if (en2) begin
        v2_d = v1_q;
        if (v1_q) begin
          out_d = result;
          ovf_d = ovf_q | diff_ovf;
        end
      end
      if (en1) begin
        v1_d = in_xfer;
        if (in_xfer) begin
          s1_y_d  = bus.in_data;
          s1_yp_d = yp_q;
          yp_d    = bus.in_data;
        end
      end
    end
  end

endmodule
